// File: rtl/true_top_pkg.sv
`default_nettype none
// true_top_pkg: shared types and default parameters for the toy RSA decryptor.
package true_top_pkg;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_N_MOD  = 3233;
  localparam int DEF_D_EXP  = 2753;
  localparam int DEF_D_BITS = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    SQUARE = 3'd2,
    MULT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef enum logic {
    VIEW_CIPHER = 1'b0,
    VIEW_PLAIN  = 1'b1
  } view_t;
endpackage
`default_nettype wire

// File: rtl/true_top_mod_mul.sv
`default_nettype none
// mod_mul: sequential (a*b) mod m by interleaved shift-add, one bit of b per cycle, MSB first.
// Requires a < mod. The start cycle already performs the first step, so p is ready after WIDTH cycles.
module mod_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mod,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, b_q, a_in;
  logic [WIDTH+1:0] acc, acc_in, mod_x, addend, sum, red1, red2;
  logic [CW-1:0]    cnt;
  logic             load, bit_in;

  assign load = start && !busy;
  assign p    = acc[WIDTH-1:0];

  // acc < mod on entry, so 2*acc + a < 3*mod and two conditional subtracts suffice.
  always_comb begin
    acc_in = load ? '0 : acc;
    bit_in = load ? b[WIDTH-1] : b_q[WIDTH-1];
    a_in   = load ? a : a_q;
    mod_x  = {2'b00, mod};
    addend = bit_in ? {2'b00, a_in} : '0;
    sum    = {acc_in[WIDTH:0], 1'b0} + addend;
    red1   = (sum >= mod_x) ? (sum - mod_x) : sum;
    red2   = (red1 >= mod_x) ? (red1 - mod_x) : red1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a_q  <= a;
        b_q  <= b << 1;
        acc  <= red2;
        cnt  <= CW'(WIDTH - 1);
        busy <= 1'b1;
      end else if (busy) begin
        acc <= red2;
        b_q <= b_q << 1;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/true_top.sv
`default_nettype none
// true_top: board top of a toy RSA decryptor, m = c^D_EXP mod N_MOD, with button
// edge detection, square-and-multiply control FSM and registered LED view mux.
module true_top
  import true_top_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int N_MOD  = DEF_N_MOD,
  parameter int D_EXP  = DEF_D_EXP,
  parameter int D_BITS = DEF_D_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btnU,
  input  logic             btnC,
  input  logic             btnD,
  output logic [WIDTH-1:0] led
);
  localparam int                IW    = (D_BITS > 1) ? $clog2(D_BITS) : 1;
  localparam logic [D_BITS-1:0] D_VEC = D_BITS'(D_EXP);
  localparam logic [WIDTH-1:0]  MOD_W = WIDTH'(N_MOD);

  logic btnU_q, btnC_q, btnD_q;
  logic u_ev, c_ev, d_ev;

  state_t           state;
  view_t            view;
  logic [WIDTH-1:0] cipher, plain, base, r;
  logic [IW-1:0]    i;

  logic             mm_start, mm_busy, mm_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_p;

  assign u_ev = btnU & ~btnU_q;
  assign c_ev = btnC & ~btnC_q;
  assign d_ev = btnD & ~btnD_q;

  mod_mul #(.WIDTH(WIDTH)) u_mod_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .mod   (MOD_W),
    .busy  (mm_busy),
    .done  (mm_done),
    .p     (mm_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btnU_q <= 1'b0;
      btnC_q <= 1'b0;
      btnD_q <= 1'b0;
      view   <= VIEW_CIPHER;
      led    <= '0;
    end else begin
      btnU_q <= btnU;
      btnC_q <= btnC;
      btnD_q <= btnD;
      if (d_ev) view <= (view == VIEW_CIPHER) ? VIEW_PLAIN : VIEW_CIPHER;
      led <= (view == VIEW_PLAIN) ? plain : cipher;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cipher   <= '0;
      plain    <= '0;
      base     <= '0;
      r        <= '0;
      i        <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
    end else begin
      mm_start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (u_ev) begin
            cipher <= sw;
          end else if (c_ev) begin
            state    <= REDUCE;
            mm_start <= 1'b1;
            mm_a     <= WIDTH'(1);
            mm_b     <= cipher;
          end
        end
        REDUCE: begin
          if (mm_done) begin
            base     <= mm_p;
            r        <= WIDTH'(1);
            i        <= IW'(D_BITS - 1);
            state    <= SQUARE;
            mm_start <= 1'b1;
            mm_a     <= WIDTH'(1);
            mm_b     <= WIDTH'(1);
          end
        end
        SQUARE: begin
          if (mm_done) begin
            r <= mm_p;
            if (D_VEC[i]) begin
              state    <= MULT;
              mm_start <= 1'b1;
              mm_a     <= mm_p;
              mm_b     <= base;
            end else if (i == '0) begin
              state <= DONE;
              plain <= mm_p;
            end else begin
              i        <= i - 1'b1;
              state    <= SQUARE;
              mm_start <= 1'b1;
              mm_a     <= mm_p;
              mm_b     <= mm_p;
            end
          end
        end
        MULT: begin
          if (mm_done) begin
            r <= mm_p;
            if (i == '0) begin
              state <= DONE;
              plain <= mm_p;
            end else begin
              i        <= i - 1'b1;
              state    <= SQUARE;
              mm_start <= 1'b1;
              mm_a     <= mm_p;
              mm_b     <= mm_p;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_true_top.sv
`default_nettype none
// tb_true_top: directed scoreboard bench for true_top at default and small parameters.
module tb_true_top;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0, sw2 = '0;
  logic        btnU = 0, btnC = 0, btnD = 0;
  logic        btnU2 = 0, btnC2 = 0, btnD2 = 0;
  logic [15:0] led, led2;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  true_top dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btnU(btnU), .btnC(btnC), .btnD(btnD), .led(led)
  );

  true_top #(.WIDTH(16), .N_MOD(33), .D_EXP(7), .D_BITS(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .sw(sw2), .btnU(btnU2), .btnC(btnC2), .btnD(btnD2), .led(led2)
  );

  function automatic logic [15:0] modexp(longint c, longint d, longint n);
    longint res, b;
    res = 1;
    b   = c % n;
    while (d > 0) begin
      if (d[0]) res = (res * b) % n;
      b = (b * b) % n;
      d = d >> 1;
    end
    return res[15:0];
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [15:0] obs);
    logic [15:0] e;
    e = exp_q.pop_front();
    compared++;
    assert (obs === e)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  task automatic pulse_u(); btnU = 1; step(1); btnU = 0; step(1); endtask
  task automatic pulse_c(); btnC = 1; step(1); btnC = 0; step(1); endtask
  task automatic pulse_d(); btnD = 1; step(1); btnD = 0; step(2); endtask

  // Starts and ends with the LEDs in cipher view.
  task automatic run_case(string tag, logic [15:0] c, logic [15:0] expect_plain);
    sw = c;
    pulse_u();
    pulse_c();
    exp_q.push_back(expect_plain);
    step(600);
    pulse_d();
    check(tag, led);
    pulse_d();
  endtask

  task automatic run_case2(string tag, logic [15:0] c, logic [15:0] expect_plain);
    sw2 = c;
    btnU2 = 1; step(1); btnU2 = 0; step(1);
    btnC2 = 1; step(1); btnC2 = 0; step(1);
    exp_q.push_back(expect_plain);
    step(300);
    btnD2 = 1; step(1); btnD2 = 0; step(2);
    check(tag, led2);
    btnD2 = 1; step(1); btnD2 = 0; step(2);
  endtask

  initial begin
    logic [15:0] rv;
    rst_n = 0;
    step(3);
    rst_n = 1;
    step(1);
    exp_q.push_back(16'd0); check("reset_led", led);

    pulse_d(); exp_q.push_back(16'd0); check("plain_after_reset", led);
    pulse_d(); exp_q.push_back(16'd0); check("cipher_after_reset", led);

    // Known textbook vector
    sw = 16'd2790;
    pulse_u();
    exp_q.push_back(16'd2790); check("load_2790", led);
    pulse_c();
    exp_q.push_back(16'd65);
    step(10000);
    pulse_d(); check("known_2790", led);
    pulse_d();

    // Two-cycle-wide load pulse
    sw = 16'd11;
    btnU = 1; step(2); btnU = 0; step(2);
    exp_q.push_back(16'd11); check("load_11", led);
    step(10000);
    pulse_c();
    exp_q.push_back(modexp(11, 2753, 3233));
    step(10000);
    pulse_d(); check("default_11", led);
    pulse_d();

    run_case("cipher_0", 16'd0, 16'd0);
    run_case("cipher_1", 16'd1, 16'd1);
    run_case("cipher_N", 16'd3233, 16'd0);
    rv = 16'($urandom_range(0, 65535));
    run_case("random_a", rv, modexp(longint'(rv), 2753, 3233));
    rv = 16'($urandom_range(3233, 65535));
    run_case("random_big", rv, modexp(longint'(rv), 2753, 3233));

    // Busy protocol: load/start during computation are ignored
    run_case("plain_100", 16'd100, modexp(100, 2753, 3233));
    sw = 16'd200;
    pulse_u();
    pulse_c();
    step(100);
    sw = 16'd300;
    pulse_u();
    pulse_c();
    exp_q.push_back(16'd200); check("busy_load_ignored", led);
    exp_q.push_back(modexp(200, 2753, 3233));
    step(360);
    pulse_d(); check("busy_start_ignored", led);
    pulse_d();

    // Held start button
    sw = 16'd5;
    pulse_u();
    btnC = 1; step(50); btnC = 0; step(1);
    exp_q.push_back(modexp(5, 2753, 3233));
    step(450);
    pulse_d(); check("held_start", led);
    pulse_d();

    // Reset during computation
    sw = 16'd7;
    pulse_u();
    pulse_c();
    step(100);
    rst_n = 0; step(1); rst_n = 1; step(1);
    exp_q.push_back(16'd0); check("midreset_led", led);
    pulse_d(); exp_q.push_back(16'd0); check("midreset_plain", led);
    step(600);
    exp_q.push_back(16'd0); check("midreset_discarded", led);
    pulse_d(); exp_q.push_back(16'd0); check("midreset_cipher", led);

    // Small parameter set
    run_case2("p33_11", 16'd11, 16'd11);
    run_case2("p33_2", 16'd2, 16'd29);
    run_case2("p33_40", 16'd40, 16'd28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
